// File: rtl/axi4_lite_master.sv
// rtl/axi4_lite_master.sv - single-outstanding AXI4-Lite initiator
// Turns one-shot requester commands into AW/W/B or AR/R handshakes with a one-cycle completion pulse.
module axi4_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  done_o,
  output logic [1:0]            done_resp_o,
  output logic [DATA_WIDTH-1:0] done_rdata_o,
  output logic [ADDR_WIDTH-1:0] awaddr_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rvalid_i,
  output logic                  rready_o
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA} state_t;

  state_t state, state_n;
  logic   aw_done, w_done;
  logic   accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_fin, w_fin;

  always_comb begin
    state_n = state;
    accept  = cmd_valid_i && cmd_ready_o;
    aw_hs   = awvalid_o && awready_i;
    w_hs    = wvalid_o && wready_i;
    b_hs    = bvalid_i && bready_o;
    ar_hs   = arvalid_o && arready_i;
    r_hs    = rvalid_i && rready_o;
    // A channel counts as finished if it handshook earlier or is handshaking now.
    aw_fin  = aw_done || aw_hs;
    w_fin   = w_done || w_hs;
    case (state)
      IDLE:    if (accept) state_n = cmd_write_i ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_fin && w_fin) state_n = WR_RESP;
      WR_RESP: if (b_hs) state_n = IDLE;
      RD_REQ:  if (ar_hs) state_n = RD_DATA;
      RD_DATA: if (r_hs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      cmd_ready_o  <= 1'b0;
      done_o       <= 1'b0;
      done_resp_o  <= 2'b00;
      done_rdata_o <= '0;
      awaddr_o     <= '0;
      awvalid_o    <= 1'b0;
      wdata_o      <= '0;
      wvalid_o     <= 1'b0;
      bready_o     <= 1'b0;
      araddr_o     <= '0;
      arvalid_o    <= 1'b0;
      rready_o     <= 1'b0;
    end else begin
      state       <= state_n;
      // Registered so it stays low through reset and rises together with done_o.
      cmd_ready_o <= (state_n == IDLE);
      done_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (cmd_write_i) begin
              awaddr_o  <= cmd_addr_i;
              wdata_o   <= cmd_wdata_i;
              awvalid_o <= 1'b1;
              wvalid_o  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
            end else begin
              araddr_o  <= cmd_addr_i;
              arvalid_o <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            awvalid_o <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_o <= 1'b0;
            w_done   <= 1'b1;
          end
          if (aw_fin && w_fin) bready_o <= 1'b1;
        end
        WR_RESP: begin
          if (b_hs) begin
            bready_o     <= 1'b0;
            done_o       <= 1'b1;
            done_resp_o  <= bresp_i;
            done_rdata_o <= '0;
          end
        end
        RD_REQ: begin
          if (ar_hs) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            rready_o     <= 1'b0;
            done_o       <= 1'b1;
            done_resp_o  <= rresp_i;
            done_rdata_o <= rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb/tb_axi4_lite_master.sv - directed bench for axi4_lite_master
// A delay-programmable behavioural slave answers the master; tests check hand-computed values.
module tb_axi4_lite_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic        done_o;
  logic [1:0]  done_resp_o;
  logic [31:0] done_rdata_o;
  logic [31:0] awaddr_o, wdata_o, araddr_o, rdata_i;
  logic        awvalid_o, awready_i, wvalid_o, wready_i;
  logic [1:0]  bresp_i, rresp_i;
  logic        bvalid_i, bready_o, arvalid_o, arready_i, rvalid_i, rready_o;

  axi4_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .done_o(done_o), .done_resp_o(done_resp_o), .done_rdata_o(done_rdata_o),
    .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Slave knobs and state
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic        have_aw, have_w, b_pend, r_pend;
  logic [31:0] aw_addr_l, w_data_l, r_data_l;
  logic [1:0]  b_resp_l, r_resp_l;
  logic [31:0] mem [16];

  function automatic logic [1:0] slave_resp(input logic [31:0] a);
    if (a >= 32'h40) return 2'b11;
    if (a == 32'h10) return 2'b10;
    return 2'b00;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0;
    arready_i = 0; rvalid_i = 0; rresp_i = 0; rdata_i = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0;
    aw_addr_l = 0; w_data_l = 0; r_data_l = 0; b_resp_l = 0; r_resp_l = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        awready_i = 0; wready_i = 0; bvalid_i = 0; arready_i = 0; rvalid_i = 0;
        have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (b_pend) begin
          if (b_cnt >= b_delay) begin
            bvalid_i = 1; bresp_i = b_resp_l;
            if (bready_o) b_pend = 0;
          end else begin bvalid_i = 0; b_cnt++; end
        end else begin bvalid_i = 0; b_cnt = 0; end
        if (r_pend) begin
          if (r_cnt >= r_delay) begin
            rvalid_i = 1; rresp_i = r_resp_l; rdata_i = r_data_l;
            if (rready_o) r_pend = 0;
          end else begin rvalid_i = 0; r_cnt++; end
        end else begin rvalid_i = 0; r_cnt = 0; end
        if (awvalid_o && !have_aw) begin
          if (aw_cnt >= aw_delay) begin awready_i = 1; have_aw = 1; aw_addr_l = awaddr_o; end
          else begin awready_i = 0; aw_cnt++; end
        end else begin awready_i = 0; aw_cnt = 0; end
        if (wvalid_o && !have_w) begin
          if (w_cnt >= w_delay) begin wready_i = 1; have_w = 1; w_data_l = wdata_o; end
          else begin wready_i = 0; w_cnt++; end
        end else begin wready_i = 0; w_cnt = 0; end
        if (have_aw && have_w) begin
          b_resp_l = slave_resp(aw_addr_l);
          if (b_resp_l == 2'b00) mem[aw_addr_l[5:2]] = w_data_l;
          b_pend = 1; b_cnt = 0; have_aw = 0; have_w = 0;
        end
        if (arvalid_o) begin
          if (ar_cnt >= ar_delay) begin
            arready_i = 1;
            r_resp_l = slave_resp(araddr_o);
            r_data_l = (r_resp_l == 2'b00) ? mem[araddr_o[5:2]] : 32'h0;
            r_pend = 1; r_cnt = 0;
          end else begin arready_i = 0; ar_cnt++; end
        end else begin arready_i = 0; ar_cnt = 0; end
      end
    end
  end

  // Results of the most recent do_cmd
  int          lat, wn, awc, wc, bb;
  logic [1:0]  rsp;
  logic [31:0] rdv;

  // Issues one command at a negedge; returns at the negedge where done_o is seen (lat = -1 on timeout).
  task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int o_lat, output int o_wait, output int o_awc, output int o_wc,
                        output int o_busy, output logic [1:0] o_resp, output logic [31:0] o_rd);
    o_wait = 0;
    while (!cmd_ready_o && o_wait < 50) begin @(negedge clk); o_wait++; end
    cmd_valid_i = 1; cmd_write_i = wr; cmd_addr_i = a; cmd_wdata_i = d;
    @(negedge clk);
    cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = 0; cmd_wdata_i = 0;
    o_lat = 1; o_awc = 0; o_wc = 0; o_busy = 0;
    while (!done_o && o_lat < 60) begin
      o_awc += int'(awvalid_o);
      o_wc  += int'(wvalid_o);
      if (cmd_ready_o) o_busy++;
      @(negedge clk);
      o_lat++;
    end
    o_resp = done_resp_o;
    o_rd   = done_rdata_o;
    if (!done_o) o_lat = -1;
  endtask

  task automatic test_reset();
    reset = 1; cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = 0; cmd_wdata_i = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cmd_ready_o, done_o, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, done_resp_o} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0", {cmd_ready_o, done_o, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, done_resp_o});
    end
    vectors++;
    if ({awaddr_o, araddr_o, wdata_o, done_rdata_o} !== 128'b0) begin
      miscompares++;
      $display("FAIL reset_data: awaddr=%h araddr=%h wdata=%h rdata=%h want 0", awaddr_o, araddr_o, wdata_o, done_rdata_o);
    end
    reset = 0;
    @(negedge clk);
    vectors++;
    if (cmd_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_after: got %b want 1", cmd_ready_o);
    end
  endtask

  task automatic test_write_read();
    do_cmd(1'b1, 32'h4, 32'hDEADBEEF, lat, wn, awc, wc, bb, rsp, rdv);
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL wr_latency: got %0d want 3", lat); end
    vectors++;
    if (awc !== 1 || wc !== 1) begin miscompares++; $display("FAIL wr_valid_cycles: aw=%0d w=%0d want 1/1", awc, wc); end
    vectors++;
    if (rsp !== 2'b00 || rdv !== 32'h0) begin miscompares++; $display("FAIL wr_done: resp=%b rdata=%h want 00/0", rsp, rdv); end
    vectors++;
    if (bb !== 0) begin miscompares++; $display("FAIL wr_busy_ready: got %0d want 0", bb); end
    do_cmd(1'b0, 32'h4, 32'h0, lat, wn, awc, wc, bb, rsp, rdv);
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL rd_latency: got %0d want 3", lat); end
    vectors++;
    if (rsp !== 2'b00 || rdv !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_done: resp=%b rdata=%h want 00/deadbeef", rsp, rdv); end
  endtask

  task automatic test_error_resp();
    do_cmd(1'b1, 32'h10, 32'h5, lat, wn, awc, wc, bb, rsp, rdv);
    vectors++;
    if (rsp !== 2'b10 || rdv !== 32'h0) begin miscompares++; $display("FAIL slverr_wr: resp=%b rdata=%h want 10/0", rsp, rdv); end
    do_cmd(1'b0, 32'h10, 32'h0, lat, wn, awc, wc, bb, rsp, rdv);
    vectors++;
    if (rsp !== 2'b10) begin miscompares++; $display("FAIL slverr_rd: resp=%b want 10", rsp); end
    do_cmd(1'b0, 32'h80, 32'h0, lat, wn, awc, wc, bb, rsp, rdv);
    vectors++;
    if (rsp !== 2'b11) begin miscompares++; $display("FAIL decerr_rd: resp=%b want 11", rsp); end
  endtask

  task automatic test_skewed();
    int n;
    aw_delay = 2; w_delay = 0;
    n = 0;
    while (!cmd_ready_o && n < 50) begin @(negedge clk); n++; end
    cmd_valid_i = 1; cmd_write_i = 1; cmd_addr_i = 32'h8; cmd_wdata_i = 32'hCAFEF00D;
    @(negedge clk);
    cmd_valid_i = 0; cmd_write_i = 0;
    vectors++;
    if ({awvalid_o, wvalid_o, bready_o} !== 3'b110) begin miscompares++; $display("FAIL skew_c1: aw/w/b=%b want 110", {awvalid_o, wvalid_o, bready_o}); end
    @(negedge clk);
    vectors++;
    if ({awvalid_o, wvalid_o, bready_o} !== 3'b100 || awaddr_o !== 32'h8) begin
      miscompares++; $display("FAIL skew_c2: aw/w/b=%b awaddr=%h want 100/8", {awvalid_o, wvalid_o, bready_o}, awaddr_o);
    end
    @(negedge clk);
    vectors++;
    if ({awvalid_o, wvalid_o, bready_o} !== 3'b100 || awaddr_o !== 32'h8) begin
      miscompares++; $display("FAIL skew_c3: aw/w/b=%b awaddr=%h want 100/8", {awvalid_o, wvalid_o, bready_o}, awaddr_o);
    end
    @(negedge clk);
    vectors++;
    if ({awvalid_o, wvalid_o, bready_o} !== 3'b001) begin miscompares++; $display("FAIL skew_c4: aw/w/b=%b want 001", {awvalid_o, wvalid_o, bready_o}); end
    @(negedge clk);
    vectors++;
    if (done_o !== 1'b1 || done_resp_o !== 2'b00) begin miscompares++; $display("FAIL skew_done: done=%b resp=%b want 1/00", done_o, done_resp_o); end
    aw_delay = 0;
    do_cmd(1'b0, 32'h8, 32'h0, lat, wn, awc, wc, bb, rsp, rdv);
    vectors++;
    if (rdv !== 32'hCAFEF00D) begin miscompares++; $display("FAIL skew_readback: got %h want cafef00d", rdv); end
  endtask

  task automatic test_back_pressure();
    b_delay = 5;
    do_cmd(1'b1, 32'h0C, 32'h0000_1234, lat, wn, awc, wc, bb, rsp, rdv);
    b_delay = 0;
    vectors++;
    if (lat !== 8) begin miscompares++; $display("FAIL bp_wr_latency: got %0d want 8", lat); end
    vectors++;
    if (bb !== 0) begin miscompares++; $display("FAIL bp_wr_busy: cmd_ready high %0d cycles want 0", bb); end
    ar_delay = 3;
    do_cmd(1'b0, 32'h0C, 32'h0, lat, wn, awc, wc, bb, rsp, rdv);
    ar_delay = 0;
    vectors++;
    if (lat !== 6 || rdv !== 32'h0000_1234) begin miscompares++; $display("FAIL bp_rd: lat=%0d rdata=%h want 6/1234", lat, rdv); end
    vectors++;
    if (bb !== 0) begin miscompares++; $display("FAIL bp_rd_busy: cmd_ready high %0d cycles want 0", bb); end
  endtask

  task automatic test_back_to_back();
    do_cmd(1'b1, 32'h20, 32'h1111_2222, lat, wn, awc, wc, bb, rsp, rdv);
    do_cmd(1'b0, 32'h20, 32'h0, lat, wn, awc, wc, bb, rsp, rdv);
    vectors++;
    if (wn !== 0 || lat !== 3) begin miscompares++; $display("FAIL b2b_rd: wait=%0d lat=%0d want 0/3", wn, lat); end
    vectors++;
    if (rdv !== 32'h1111_2222) begin miscompares++; $display("FAIL b2b_rdata: got %h want 11112222", rdv); end
    @(negedge clk);
    vectors++;
    if (done_o !== 1'b0 || done_rdata_o !== 32'h1111_2222 || done_resp_o !== 2'b00) begin
      miscompares++; $display("FAIL b2b_hold: done=%b rdata=%h resp=%b want 0/11112222/00", done_o, done_rdata_o, done_resp_o);
    end
  endtask

  task automatic test_reset_mid_transfer();
    int n;
    int done_seen;
    aw_delay = 20; w_delay = 20;
    cmd_valid_i = 1; cmd_write_i = 1; cmd_addr_i = 32'h4; cmd_wdata_i = 32'h0BAD_0BAD;
    @(negedge clk);
    cmd_valid_i = 0; cmd_write_i = 0;
    vectors++;
    if (wvalid_o !== 1'b1) begin miscompares++; $display("FAIL mid_wvalid: got %b want 1", wvalid_o); end
    reset = 1;
    @(negedge clk);
    vectors++;
    if ({cmd_ready_o, done_o, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, done_resp_o} !== 9'b0 ||
        {awaddr_o, araddr_o, wdata_o, done_rdata_o} !== 128'b0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: ctrl=%b awaddr=%h wdata=%h want all 0",
               {cmd_ready_o, done_o, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, done_resp_o}, awaddr_o, wdata_o);
    end
    reset = 0; aw_delay = 0; w_delay = 0;
    done_seen = 0; n = 0;
    while (!cmd_ready_o && n < 20) begin
      if (done_o) done_seen++;
      @(negedge clk); n++;
    end
    vectors++;
    if (done_seen !== 0 || cmd_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL mid_recover: done pulses=%0d cmd_ready=%b want 0/1", done_seen, cmd_ready_o);
    end
    do_cmd(1'b0, 32'h4, 32'h0, lat, wn, awc, wc, bb, rsp, rdv);
    vectors++;
    if (lat !== 3 || rsp !== 2'b00 || rdv !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL mid_read_after: lat=%0d resp=%b rdata=%h want 3/00/deadbeef", lat, rsp, rdv);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_error_resp();
    test_skewed();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_transfer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
